// File: rtl/key_challenger.sv
// key_challenger: replays a loaded challenge on the CLE208 key bus and checks the 1-bit responses.
// Latency: start-to-done = 1 + N*(SETUP_CYC+3) cycles; empty buffer finishes in 1 cycle.
// Backpressure: pushes, clears and starts are ignored while busy; a push into a full buffer sets ch_ovf.
// Option: define KEY_CHALLENGER_ABORT_EN to end the sequence after the first mismatching step.
module key_challenger #(
  parameter int STEPS     = 16,
  parameter int SETUP_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_wr,
  input  logic [4:0]  ch_wdata,
  input  logic        ch_clr,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] resp,
  output logic [4:0]  ch_count,
  output logic        ch_ovf,
  output logic        sser_n,
  output logic        ba13,
  output logic        ba12,
  output logic [3:0]  ba_nib,
  output logic        br_w,
  output logic        key_clk,
  input  logic        key_d
);

  localparam int AW = $clog2(STEPS);

  typedef enum logic [2:0] {IDLE, SETUP, SAMPLE, CLOCK, RECOVER, FINISH} state_t;

  state_t      state, state_nxt;
  logic [4:0]  mem [STEPS];
  logic [3:0]  step;
  logic [2:0]  scnt;
  logic        mismatch;
  logic        clr_ok, wr_ok, ovf_set, last, stop, active;
  logic [4:0]  count_upd;
  logic [4:0]  cur;

  // Buffer write/clear qualification; count_upd lets a same-cycle start see the new entry.
  always_comb begin
    clr_ok    = ch_clr & ~busy;
    wr_ok     = ch_wr & ~busy & ~clr_ok & (ch_count < 5'(STEPS));
    ovf_set   = ch_wr & ~busy & ~clr_ok & (ch_count == 5'(STEPS));
    count_upd = clr_ok ? 5'd0 : (wr_ok ? ch_count + 5'd1 : ch_count);
    cur       = mem[step[AW-1:0]];
    last      = ({1'b0, step} + 5'd1) >= ch_count;
`ifdef KEY_CHALLENGER_ABORT_EN
    stop      = last | mismatch;
`else
    stop      = last;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one step is SETUP_CYC setup cycles, then sample, clock and recover.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count_upd != 5'd0) ? SETUP : FINISH;
      SETUP:   if (scnt == 3'(SETUP_CYC - 1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = CLOCK;
      CLOCK:   state_nxt = RECOVER;
      RECOVER: state_nxt = stop ? FINISH : SETUP;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Key bus outputs decoded from the state; address and select are held across sample and clock.
  always_comb begin
    active  = (state == SETUP) || (state == SAMPLE) || (state == CLOCK);
    sser_n  = ~active;
    ba13    = 1'b0;
    ba12    = active;
    br_w    = active;
    key_clk = (state == CLOCK);
    ba_nib  = active ? cur[3:0] : 4'd0;
  end

  // Challenge storage; contents need no reset since ch_count defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[ch_count[AW-1:0]] <= ch_wdata;
  end

  // Buffer bookkeeping, step sequencing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_count <= 5'd0;
      ch_ovf   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      resp     <= 16'd0;
      step     <= 4'd0;
      scnt     <= 3'd0;
      mismatch <= 1'b0;
    end else begin
      ch_count <= count_upd;
      if (clr_ok)       ch_ovf <= 1'b0;
      else if (ovf_set) ch_ovf <= 1'b1;
      if (clr_ok) begin
        done <= 1'b0;
        pass <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          busy     <= (count_upd != 5'd0);
          done     <= 1'b0;
          pass     <= 1'b0;
          resp     <= 16'd0;
          mismatch <= 1'b0;
          step     <= 4'd0;
          scnt     <= 3'd0;
        end
        SETUP:  scnt <= scnt + 3'd1;
        SAMPLE: begin
          resp[step] <= key_d;
          if (key_d != cur[4]) mismatch <= 1'b1;
        end
        RECOVER: begin
          step <= step + 4'd1;
          scnt <= 3'd0;
        end
        // busy is only set for a non-empty run, so an empty start always reports fail.
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= busy & ~mismatch;
        end
        default: ;
      endcase
    end
  end

endmodule
